// File: rtl/imem_load_ctrl.sv
// Arbitrates the single-port instruction memory between CPU fetch and a byte-serial loader.
// Loaded bytes are packed big-endian and written to consecutive words starting at word 0.
module imem_load_ctrl #(
  parameter int DEPTH_LOG2 = 6,
  parameter int PC_W       = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [PC_W-1:0]       PC_next,
  output logic [31:0]           instruction,
  output logic                  cpu_stall,
  output logic                  pc_misaligned,
  output logic [DEPTH_LOG2-1:0] mem_addr,
  output logic                  mem_we,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  load_start,
  input  logic [7:0]            load_byte,
  input  logic                  load_byte_valid,
  output logic                  load_byte_ready,
  input  logic                  load_done,
  output logic [DEPTH_LOG2:0]   load_count
);

  typedef enum logic [1:0] {RUN, LOAD, WRITE} state_t;

  localparam logic [DEPTH_LOG2-1:0] WPTR_LAST = '1;
  localparam logic [DEPTH_LOG2-1:0] WPTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2+1)'(1);

  state_t                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   wptr_q, wptr_d;
  logic [2:0]              bcnt_q, bcnt_d;
  logic [DEPTH_LOG2:0]     cnt_q, cnt_d;
  logic [31:0]             sr_q, sr_d;
  logic                    done_q, done_d;
  logic                    stall_q, stall_d;
  logic                    ready_q, ready_d;
  logic                    we_q, we_d;

  logic                    accept;
  logic [31:0]             sr_acc;
  logic [2:0]              bcnt_acc;

  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    bcnt_d   = bcnt_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    done_d   = done_q;
    accept   = load_byte_valid && ready_q;
    sr_acc   = accept ? {sr_q[23:0], load_byte} : sr_q;
    bcnt_acc = bcnt_q + {2'b00, accept};

    case (state_q)
      RUN: begin
        if (load_start) begin
          state_d = LOAD;
          wptr_d  = '0;
          bcnt_d  = '0;
          cnt_d   = '0;
          sr_d    = '0;
          done_d  = 1'b0;
        end
      end
      LOAD: begin
        sr_d   = sr_acc;
        bcnt_d = bcnt_acc;
        if (bcnt_acc == 3'd4) begin
          // A byte completing a word wins over done; done is remembered for WRITE's exit.
          state_d = WRITE;
          done_d  = load_done;
        end else if (load_done) begin
          if (bcnt_acc == 3'd0) begin
            state_d = RUN;
          end else begin
            state_d = WRITE;
            done_d  = 1'b1;
            case (bcnt_acc)
              3'd1:    sr_d = {sr_acc[7:0], 24'h0};
              3'd2:    sr_d = {sr_acc[15:0], 16'h0};
              3'd3:    sr_d = {sr_acc[23:0], 8'h0};
              default: sr_d = sr_acc;
            endcase
          end
        end
      end
      WRITE: begin
        wptr_d  = wptr_q + WPTR_ONE;
        cnt_d   = cnt_q + CNT_ONE;
        bcnt_d  = '0;
        state_d = (wptr_q == WPTR_LAST || done_q) ? RUN : LOAD;
      end
      default: state_d = RUN;
    endcase

    // Handshake and strobe outputs are registered off the next state.
    stall_d = (state_d != RUN);
    ready_d = (state_d == LOAD);
    we_d    = (state_d == WRITE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      wptr_q  <= '0;
      bcnt_q  <= '0;
      cnt_q   <= '0;
      sr_q    <= '0;
      done_q  <= 1'b0;
      stall_q <= 1'b0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      bcnt_q  <= bcnt_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      done_q  <= done_d;
      stall_q <= stall_d;
      ready_q <= ready_d;
      we_q    <= we_d;
    end
  end

  assign mem_addr        = (state_q == RUN) ? PC_next[DEPTH_LOG2+1:2] : wptr_q;
  assign instruction     = (state_q == RUN) ? mem_rdata : 32'h0;
  assign pc_misaligned   = (state_q == RUN) && (PC_next[1:0] != 2'b00);
  assign cpu_stall       = stall_q;
  assign load_byte_ready = ready_q;
  assign mem_we          = we_q;
  assign mem_wdata       = we_q ? sr_q : 32'h0;
  assign load_count      = cnt_q;

endmodule
